pc_gen_ras: RTL and testbench

//  Parametrised program-counter generator for the pipelined beta CPU fetch stage.

---
 rtl/pc_gen_ras_if.sv | 33 +++
 rtl/pc_gen_ras.sv | 141 ++++++++++++++
 tb/tb_pc_gen_ras.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pc_gen_ras_if.sv
// Decode-to-fetch bus for pc_gen_ras: select/operand inputs and the registered
// fetch address, branch status and return-stack status outputs.
interface pc_gen_ras_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned OFS_W     = 16,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             clk_en;
  logic             stall;
  logic [2:0]       pcsel;
  logic [XLEN-1:0]  pc_in;
  logic [OFS_W-1:0] offset;
  logic [XLEN-1:0]  address;
  logic [XLEN-1:0]  pc_out;
  logic [XLEN-1:0]  pc_next;
  logic             taken;
  logic             misalign_err;
  logic             ras_underflow;
  logic             ras_overflow;
  logic [CNT_W-1:0] ras_count;

  modport master (
    output clk_en, stall, pcsel, pc_in, offset, address,
    input  pc_out, pc_next, taken, misalign_err, ras_underflow, ras_overflow, ras_count
  );

  modport slave (
    input  clk_en, stall, pcsel, pc_in, offset, address,
    output pc_out, pc_next, taken, misalign_err, ras_underflow, ras_overflow, ras_count
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch-stage program-counter generator with branch/jump/call/return/trap
// selection, misalignment trap and a circular return-address stack.
module pc_gen_ras #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     OFS_W     = 16,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h80,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  pc_gen_ras_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    SEL_NORMAL  = 3'b000,
    SEL_BEQ     = 3'b001,
    SEL_JMP     = 3'b010,
    SEL_BNE     = 3'b011,
    SEL_CALL    = 3'b100,
    SEL_RET     = 3'b101,
    SEL_TRAP    = 3'b110,
    SEL_NORMAL7 = 3'b111
  } pcsel_e;

  logic [XLEN-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_pc_out;
  logic [XLEN-1:0]  r_pc_next;
  logic             r_taken;
  logic             r_misalign;
  logic             r_underflow;
  logic             r_overflow;

  pcsel_e           w_sel;
  logic             w_update;
  logic [XLEN-1:0]  w_tgt;
  logic [XLEN-1:0]  w_br_tgt;
  logic             w_taken;
  logic             w_misalign;
  logic             w_underflow;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [PTR_W-1:0] w_push_idx;

  assign w_sel      = pcsel_e'(bus.pcsel);
  assign w_update   = bus.clk_en && !bus.stall;
  assign w_full     = (r_count == CNT_W'(RAS_DEPTH));
  assign w_push_idx = PTR_W'(r_top + 1'b1);
  // Branch target is relative to the current instruction, i.e. pc_in - 4.
  assign w_br_tgt   = bus.pc_in + ({{(XLEN-OFS_W){bus.offset[OFS_W-1]}}, bus.offset} << 2)
                      - XLEN'(4);

  always_comb begin
    w_tgt       = bus.pc_in;
    w_taken     = 1'b0;
    w_misalign  = 1'b0;
    w_underflow = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    unique case (w_sel)
      SEL_BEQ: if (bus.address == '0) begin
        w_tgt   = w_br_tgt;
        w_taken = 1'b1;
      end
      SEL_BNE: if (bus.address != '0) begin
        w_tgt   = w_br_tgt;
        w_taken = 1'b1;
      end
      SEL_JMP, SEL_CALL: begin
        w_taken = 1'b1;
        if (bus.address[1:0] != 2'b00) begin
          w_tgt      = TRAP_VEC;
          w_misalign = 1'b1;
        end else begin
          w_tgt  = bus.address;
          w_push = (w_sel == SEL_CALL);
        end
      end
      SEL_RET: begin
        w_taken = 1'b1;
        if (r_count == '0) begin
          w_tgt       = TRAP_VEC;
          w_underflow = 1'b1;
        end else begin
          w_tgt = r_ras[r_top];
          w_pop = 1'b1;
        end
      end
      SEL_TRAP: begin
        w_tgt   = TRAP_VEC;
        w_taken = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_out    <= RESET_VEC;
      r_pc_next   <= RESET_VEC + XLEN'(4);
      r_top       <= '0;
      r_count     <= '0;
      r_taken     <= 1'b0;
      r_misalign  <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_update) begin
      r_pc_out    <= w_tgt;
      r_pc_next   <= w_tgt + XLEN'(4);
      r_taken     <= w_taken;
      r_misalign  <= w_misalign;
      r_underflow <= w_underflow;
      if (w_push) begin
        r_top <= w_push_idx;
        if (w_full) r_overflow <= 1'b1;
        else        r_count    <= r_count + 1'b1;
      end else if (w_pop) begin
        r_top   <= PTR_W'(r_top - 1'b1);
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Stack storage has no reset; a full stack simply overwrites its oldest slot.
  always_ff @(posedge clk) begin
    if (!rst && w_update && w_push) r_ras[w_push_idx] <= bus.pc_in;
  end

  assign bus.pc_out        = r_pc_out;
  assign bus.pc_next       = r_pc_next;
  assign bus.taken         = r_taken;
  assign bus.misalign_err  = r_misalign;
  assign bus.ras_underflow = r_underflow;
  assign bus.ras_overflow  = r_overflow;
  assign bus.ras_count     = r_count;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed self-checking bench for pc_gen_ras with hand-computed expectations.
module tb_pc_gen_ras;
  logic clk = 1'b0;
  logic rst;
  int unsigned errors = 0;
  int unsigned checks = 0;

  pc_gen_ras_if #(.XLEN(32), .OFS_W(16), .RAS_DEPTH(4)) bus ();

  pc_gen_ras #(
    .XLEN(32), .OFS_W(16), .RESET_VEC(32'h0), .TRAP_VEC(32'h80), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] pcin,
                       input logic [15:0] ofs, input logic [31:0] addr);
    bus.pcsel   = sel;
    bus.pc_in   = pcin;
    bus.offset  = ofs;
    bus.address = addr;
  endtask

  initial begin
    rst = 1'b1;
    bus.clk_en = 1'b1;
    bus.stall  = 1'b0;
    drive(3'b000, 32'h0, 16'h0, 32'h0);
    tick(); tick();
    chk("rst_pc_out", bus.pc_out, 32'h0);
    chk("rst_pc_next", bus.pc_next, 32'h4);
    chk("rst_count", 32'(bus.ras_count), 32'd0);
    chk("rst_taken", 32'(bus.taken), 32'd0);
    chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
    chk("rst_underflow", 32'(bus.ras_underflow), 32'd0);
    chk("rst_overflow", 32'(bus.ras_overflow), 32'd0);
    rst = 1'b0;

    // Branches
    drive(3'b001, 32'h100, 16'hFFFE, 32'h0); tick();
    chk("beq_pc_out", bus.pc_out, 32'hF4);
    chk("beq_pc_next", bus.pc_next, 32'hF8);
    chk("beq_taken", 32'(bus.taken), 32'd1);
    drive(3'b011, 32'h100, 16'hFFFE, 32'h0); tick();
    chk("bne_nt_pc_out", bus.pc_out, 32'h100);
    chk("bne_nt_taken", 32'(bus.taken), 32'd0);
    drive(3'b011, 32'h200, 16'h0003, 32'h5); tick();
    chk("bne_t_pc_out", bus.pc_out, 32'h208);
    chk("bne_t_taken", 32'(bus.taken), 32'd1);
    drive(3'b001, 32'h300, 16'h0003, 32'h5); tick();
    chk("beq_nt_pc_out", bus.pc_out, 32'h300);
    drive(3'b111, 32'h444, 16'h0, 32'h0); tick();
    chk("sel7_pc_out", bus.pc_out, 32'h444);
    chk("sel7_taken", 32'(bus.taken), 32'd0);

    // CALL / RET / underflow
    drive(3'b100, 32'h20, 16'h0, 32'h400); tick();
    chk("call_pc_out", bus.pc_out, 32'h400);
    chk("call_count", 32'(bus.ras_count), 32'd1);
    drive(3'b101, 32'h404, 16'h0, 32'h0); tick();
    chk("ret_pc_out", bus.pc_out, 32'h20);
    chk("ret_count", 32'(bus.ras_count), 32'd0);
    tick();
    chk("unf_pc_out", bus.pc_out, 32'h80);
    chk("unf_flag", 32'(bus.ras_underflow), 32'd1);
    chk("unf_taken", 32'(bus.taken), 32'd1);
    drive(3'b000, 32'h0, 16'h0, 32'h0); tick();
    chk("unf_pulse_clear", 32'(bus.ras_underflow), 32'd0);

    // Overflow: 5 calls into a 4-deep stack
    for (int i = 1; i <= 5; i++) begin
      drive(3'b100, 32'(i * 16), 16'h0, 32'h1000); tick();
      if (i == 4) begin
        chk("ovf_count4", 32'(bus.ras_count), 32'd4);
        chk("ovf_not_yet", 32'(bus.ras_overflow), 32'd0);
      end
    end
    chk("ovf_flag", 32'(bus.ras_overflow), 32'd1);
    chk("ovf_count", 32'(bus.ras_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(3'b101, 32'h1004, 16'h0, 32'h0); tick();
      chk($sformatf("ovf_ret%0d", i), bus.pc_out, 32'(32'h50 - i * 16));
    end
    chk("ovf_ret_count", 32'(bus.ras_count), 32'd0);
    tick();
    chk("ovf_ret5_pc", bus.pc_out, 32'h80);
    chk("ovf_ret5_unf", 32'(bus.ras_underflow), 32'd1);
    chk("ovf_sticky", 32'(bus.ras_overflow), 32'd1);

    // Stall hold
    drive(3'b110, 32'h0, 16'h0, 32'h0); tick();
    chk("trap_pc_out", bus.pc_out, 32'h80);
    bus.stall = 1'b1;
    drive(3'b010, 32'h0, 16'h0, 32'h200); tick(); tick();
    chk("stall_pc_out", bus.pc_out, 32'h80);
    chk("stall_taken", 32'(bus.taken), 32'd1);
    chk("stall_unf_held", 32'(bus.ras_underflow), 32'd0);
    bus.stall = 1'b0; tick();
    chk("unstall_pc_out", bus.pc_out, 32'h200);
    chk("unstall_pc_next", bus.pc_next, 32'h204);

    // Clock-enable hold
    drive(3'b000, 32'h300, 16'h0, 32'h0); tick();
    chk("norm_taken", 32'(bus.taken), 32'd0);
    bus.clk_en = 1'b0;
    drive(3'b010, 32'h0, 16'h0, 32'h200); tick(); tick();
    chk("cen_pc_out", bus.pc_out, 32'h300);
    chk("cen_taken", 32'(bus.taken), 32'd0);
    bus.clk_en = 1'b1; tick();
    chk("cen_rel_pc_out", bus.pc_out, 32'h200);
    chk("cen_rel_taken", 32'(bus.taken), 32'd1);

    // Reset during stall with a CALL pending: reset wins, no push
    bus.stall = 1'b1; rst = 1'b1;
    drive(3'b100, 32'h44, 16'h0, 32'h400); tick();
    chk("rst_stall_pc", bus.pc_out, 32'h0);
    chk("rst_stall_ovf", 32'(bus.ras_overflow), 32'd0);
    chk("rst_stall_count", 32'(bus.ras_count), 32'd0);
    bus.stall = 1'b0; rst = 1'b0;
    drive(3'b101, 32'h0, 16'h0, 32'h0); tick();
    chk("rst_nopush_unf", 32'(bus.ras_underflow), 32'd1);

    // Misalignment and wrap
    drive(3'b010, 32'h0, 16'h0, 32'h202); tick();
    chk("mis_jmp_pc", bus.pc_out, 32'h80);
    chk("mis_jmp_flag", 32'(bus.misalign_err), 32'd1);
    chk("mis_jmp_taken", 32'(bus.taken), 32'd1);
    drive(3'b100, 32'h60, 16'h0, 32'h403); tick();
    chk("mis_call_pc", bus.pc_out, 32'h80);
    chk("mis_call_nopush", 32'(bus.ras_count), 32'd0);
    drive(3'b000, 32'hFFFF_FFFC, 16'h0, 32'h0); tick();
    chk("wrap_pc_out", bus.pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc_next", bus.pc_next, 32'h0);
    chk("mis_pulse_clear", 32'(bus.misalign_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
